// File: rtl/fac8_2_pkg.sv
// Shared types and helpers for the fac8_2 twiddle-multiply control block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fac8_2_pkg;

   // Frame sequencer states
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Per-beat tag carried alongside the multiplier latency
   typedef struct packed {
      logic valid;
      logic sof;
      logic eof;
   } tag_t;

   // Default geometry: 512-point FFT over 16 lanes
   localparam int DEF_BEATS = 512 / 16;

   // Counter width for a beat counter spanning 0..n-1 (at least one bit)
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_BEAT_CW = cnt_width(DEF_BEATS);

endpackage

// File: rtl/fac8_2_lat_pipe.sv
// Delay line matching the mul_fac8_2 pipeline depth for beat tags.
// Latency: exactly LAT cycles from tag_in to tag_out.
// Backpressure: none; shifts every cycle, reset empties all stages.
module fac8_2_lat_pipe
   import fac8_2_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  tag_t tag_in,
   output tag_t tag_out,
   output logic any_vld
);

   tag_t stage [LAT];

   // Shift tags one stage per cycle; reset drops anything in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) stage[i] <= '0;
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
      end
   end

   assign tag_out = stage[LAT-1];

   // Any beat still travelling through the pipe keeps the block busy
   always_comb begin
      any_vld = 1'b0;
      for (int i = 0; i < LAT; i++) any_vld = any_vld | stage[i].valid;
   end

endmodule

// File: rtl/fac8_2_seq.sv
// Sequences en/addr for mul_fac8_2 and re-times frame markers to its output.
// Latency: mul_en/mul_addr combinational; out_* and frame_done MUL_LAT cycles after acceptance.
// Backpressure: none; beats without a valid frame context are dropped and flagged.
module fac8_2_seq
   import fac8_2_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int N_POINT    = 512,
   parameter int ADDR_WIDTH = 9,
   parameter int ADDR_BASE  = 0,
   parameter int ADDR_STEP  = 16,
   parameter int MUL_LAT    = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  in_sof,
   output logic                  mul_en,
   output logic [ADDR_WIDTH-1:0] mul_addr,
   output logic                  out_valid,
   output logic                  out_sof,
   output logic                  out_eof,
   output logic                  frame_done,
   output logic [CNT_WIDTH-1:0]  frame_cnt,
   output logic                  err_sof,
   output logic                  err_nosof,
   output logic                  busy
);

   localparam int BEATS = N_POINT / DEPTH;
   localparam int BCW   = cnt_width(BEATS);

   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(ADDR_BASE);
   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);
   localparam logic [BCW-1:0]        LAST = BCW'(BEATS - 1);

   state_t                  state, state_nxt;
   logic [BCW-1:0]          beat_cnt, beat_cnt_nxt;
   logic [ADDR_WIDTH-1:0]   addr_reg, addr_nxt;
   logic                    accept;
   logic                    err_sof_nxt, err_nosof_nxt;
   tag_t                    tag_in, tag_out;
   logic                    pipe_busy;

   // Accept/classify the incoming beat and compute the next frame position.
   // Outputs are gated by rst so nothing reaches the multiplier during reset.
   always_comb begin
      state_nxt     = state;
      beat_cnt_nxt  = beat_cnt;
      addr_nxt      = addr_reg;
      tag_in        = '0;
      accept        = ~rst & in_valid & (in_sof | (state == RUN));
      err_sof_nxt   = ~rst & in_valid & in_sof & (state == RUN) & (beat_cnt != '0);
      err_nosof_nxt = ~rst & in_valid & ~in_sof & (state == IDLE);
      if (accept) begin
         tag_in.valid = 1'b1;
         if (in_sof) begin
            // Start (or restart) a frame at beat 0
            tag_in.sof = 1'b1;
            if (BEATS == 1) begin
               tag_in.eof   = 1'b1;
               state_nxt    = IDLE;
               beat_cnt_nxt = '0;
               addr_nxt     = BASE;
            end else begin
               state_nxt    = RUN;
               beat_cnt_nxt = BCW'(1);
               addr_nxt     = BASE + STEP;
            end
         end else if (beat_cnt == LAST) begin
            // Final beat: close the frame so the next sof can follow immediately
            tag_in.eof   = 1'b1;
            state_nxt    = IDLE;
            beat_cnt_nxt = '0;
            addr_nxt     = BASE;
         end else begin
            beat_cnt_nxt = beat_cnt + BCW'(1);
            addr_nxt     = addr_reg + STEP;
         end
      end
   end

   assign mul_en   = accept;
   assign mul_addr = in_sof ? BASE : addr_reg;

   // Frame position and one-cycle error flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         beat_cnt  <= '0;
         addr_reg  <= BASE;
         err_sof   <= 1'b0;
         err_nosof <= 1'b0;
      end else begin
         state     <= state_nxt;
         beat_cnt  <= beat_cnt_nxt;
         addr_reg  <= addr_nxt;
         err_sof   <= err_sof_nxt;
         err_nosof <= err_nosof_nxt;
      end
   end

   fac8_2_lat_pipe #(
      .LAT (MUL_LAT)
   ) u_lat_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out),
      .any_vld (pipe_busy)
   );

   assign out_valid  = tag_out.valid;
   assign out_sof    = tag_out.sof;
   assign out_eof    = tag_out.eof;
   assign frame_done = tag_out.valid & tag_out.eof;
   assign busy       = (state == RUN) | pipe_busy;

   // Completed-frame counter, wraps naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) frame_cnt <= '0;
      else if (frame_done) frame_cnt <= frame_cnt + CNT_WIDTH'(1);
   end

endmodule

// File: tb/tb_fac8_2_seq.sv
// Directed bench for fac8_2_seq: default config (dut_a) and MUL_LAT=3/ADDR_BASE=377 (dut_b).
// Latency: expected out_* are the hand-specified beat tags delayed by the configured depth.
// Backpressure: n/a.
module tb_fac8_2_seq;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid = 1'b0;
   logic in_sof = 1'b0;

   logic        a_en, a_ov, a_os, a_oe, a_fd, a_es, a_en_err, a_busy;
   logic [8:0]  a_addr;
   logic [15:0] a_fc;
   logic        b_en, b_ov, b_os, b_oe, b_fd, b_es, b_en_err, b_busy;
   logic [8:0]  b_addr;
   logic [15:0] b_fc;

   logic        s_en, s_ov, s_os, s_oe, s_fd, s_es, s_ens, s_busy;
   logic [8:0]  s_addr;
   logic [15:0] s_fc;

   int   checks = 0;
   int   errors = 0;
   logic sel = 1'b0;
   logic [2:0] hist [4];
   logic pend_esf = 1'b0;
   logic pend_enf = 1'b0;

   always #5 clk = ~clk;

   fac8_2_seq dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
      .mul_en(a_en), .mul_addr(a_addr), .out_valid(a_ov), .out_sof(a_os),
      .out_eof(a_oe), .frame_done(a_fd), .frame_cnt(a_fc), .err_sof(a_es),
      .err_nosof(a_en_err), .busy(a_busy)
   );

   fac8_2_seq #(.MUL_LAT(3), .ADDR_BASE(377)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof),
      .mul_en(b_en), .mul_addr(b_addr), .out_valid(b_ov), .out_sof(b_os),
      .out_eof(b_oe), .frame_done(b_fd), .frame_cnt(b_fc), .err_sof(b_es),
      .err_nosof(b_en_err), .busy(b_busy)
   );

   // Route the instance under test to a common set of observation signals
   always_comb begin
      s_en   = sel ? b_en     : a_en;
      s_addr = sel ? b_addr   : a_addr;
      s_ov   = sel ? b_ov     : a_ov;
      s_os   = sel ? b_os     : a_os;
      s_oe   = sel ? b_oe     : a_oe;
      s_fd   = sel ? b_fd     : a_fd;
      s_fc   = sel ? b_fc     : a_fc;
      s_es   = sel ? b_es     : a_es;
      s_ens  = sel ? b_en_err : a_en_err;
      s_busy = sel ? b_busy   : a_busy;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One input cycle: check registered outputs, drive inputs, check combinational outputs
   task automatic cyc(input logic v, input logic s, input logic ee, input int ea,
                      input logic es, input logic eo, input logic esf, input logic enf);
      int lat;
      lat = sel ? 3 : 1;
      @(negedge clk);
      chk("out_valid",  32'(s_ov), 32'(hist[lat-1][2]));
      chk("out_sof",    32'(s_os), 32'(hist[lat-1][1]));
      chk("out_eof",    32'(s_oe), 32'(hist[lat-1][0]));
      chk("frame_done", 32'(s_fd), 32'(hist[lat-1][2] & hist[lat-1][0]));
      chk("err_sof",    32'(s_es), 32'(pend_esf));
      chk("err_nosof",  32'(s_ens), 32'(pend_enf));
      in_valid = v;
      in_sof   = s;
      #1;
      chk("mul_en", 32'(s_en), 32'(ee));
      if (ea >= 0) chk("mul_addr", 32'(s_addr), ea);
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0]  = {ee, es, eo};
      pend_esf = esf;
      pend_enf = enf;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_sof   = 1'b1;
      #1;
      chk("rst_mul_en",     32'(s_en),  0);
      chk("rst_mul_addr",   32'(s_addr), sel ? 377 : 0);
      chk("rst_out_valid",  32'(s_ov),  0);
      chk("rst_out_sof",    32'(s_os),  0);
      chk("rst_out_eof",    32'(s_oe),  0);
      chk("rst_frame_done", 32'(s_fd),  0);
      chk("rst_frame_cnt",  32'(s_fc),  0);
      chk("rst_err_sof",    32'(s_es),  0);
      chk("rst_err_nosof",  32'(s_ens), 0);
      chk("rst_busy",       32'(s_busy), 0);
      for (int i = 0; i < 4; i++) hist[i] = 3'b000;
      pend_esf = 1'b0;
      pend_enf = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      rst      = 1'b0;
   endtask

   // One full frame starting at address base, optionally with a gap after every beat
   task automatic frame(input int base, input logic gaps);
      for (int b = 0; b < 32; b++) begin
         cyc(1'b1, b == 0, 1'b1, (base + 16 * b) % 512, b == 0, b == 31, 1'b0, 1'b0);
         if (gaps) idle(1);
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) hist[i] = 3'b000;

      // Contiguous frame
      do_reset();
      frame(0, 1'b0);
      chk("busy_last_beat", 32'(s_busy), 1);
      idle(3);
      chk("frame_cnt_contig", 32'(s_fc), 1);
      chk("busy_after_frame", 32'(s_busy), 0);

      // Frame with a gap after each beat
      do_reset();
      frame(0, 1'b1);
      idle(3);
      chk("frame_cnt_gaps", 32'(s_fc), 1);

      // Two frames back to back
      do_reset();
      frame(0, 1'b0);
      frame(0, 1'b0);
      idle(3);
      chk("frame_cnt_b2b", 32'(s_fc), 2);

      // Restart with sof at beat 10
      do_reset();
      for (int b = 0; b < 10; b++)
         cyc(1'b1, b == 0, 1'b1, 16 * b, b == 0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b1, 1'b0);
      for (int b = 1; b < 32; b++)
         cyc(1'b1, 1'b0, 1'b1, 16 * b, 1'b0, b == 31, 1'b0, 1'b0);
      idle(3);
      chk("frame_cnt_restart", 32'(s_fc), 1);

      // Beats without sof while idle are dropped
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 1'b0, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(3);
      chk("frame_cnt_nosof", 32'(s_fc), 1);

      // Reset in the middle of a frame, then a fresh frame
      do_reset();
      for (int b = 0; b < 20; b++)
         cyc(1'b1, b == 0, 1'b1, 16 * b, b == 0, 1'b0, 1'b0, 1'b0);
      do_reset();
      idle(2);
      frame(0, 1'b0);
      idle(3);
      chk("frame_cnt_after_rst", 32'(s_fc), 1);

      // Deeper multiplier and offset base address
      sel = 1'b1;
      do_reset();
      frame(377, 1'b0);
      idle(5);
      chk("frame_cnt_lat3", 32'(s_fc), 1);
      chk("busy_lat3_done", 32'(s_busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
